dwa_sel18: RTL and testbench

DWA_SEL18 -- requirements
Module: dwa_sel18

---
 rtl/dwa_sel18_pkg.sv | 30 +++
 rtl/dwa_sel18_bank.sv | 54 +++++
 rtl/dwa_sel18.sv | 45 ++++
 tb/tb_dwa_sel18.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dwa_sel18_pkg.sv
// Shared definitions for the 18-element DWA selector: element count default,
// pointer width derivation and the rotated-thermometer mask helper.
package dwa_sel18_pkg;

  localparam int N_ELEM_DEF = 9;
  // Widest bank the mask helper can build; callers slice down to N_ELEM.
  localparam int MASK_MAX   = 32;

  // Pointer width able to hold 0..n-1.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Thermometer of cnt ones starting at bit 'start', wrapping modulo n.
  // Assumes start < n, so a single subtraction brings any index back in range.
  function automatic logic [MASK_MAX-1:0] rot_therm(input int unsigned cnt,
                                                    input int unsigned start,
                                                    input int unsigned n);
    logic [MASK_MAX-1:0] m;
    int unsigned         idx;
    m = '0;
    for (int unsigned k = 0; k < MASK_MAX; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (k < cnt && k < n && idx < MASK_MAX) m[idx] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dwa_sel18_bank.sv
// One DWA bank: clips the requested count, builds the rotated mask from the
// current pointer and advances the pointer with a single-subtract wrap.
module dwa_bank
  import dwa_sel18_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int PTR_W  = ptr_w(N_ELEM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en_i,
  input  logic              dwa_en_i,
  input  logic [3:0]        cnt_i,
  output logic [N_ELEM-1:0] sel_o,
  output logic [PTR_W-1:0]  ptr_o,
  output logic              clip_o
);

  logic [N_ELEM-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [MASK_MAX-1:0] mask_full;
  logic                unused_mask_hi;
  int unsigned         n, start, sum;

  // Clip, pick start (fixed at 0 when rotation is off), build mask, wrap pointer.
  always_comb begin
    clip_o    = (32'(cnt_i) > N_ELEM);
    n         = clip_o ? N_ELEM : 32'(cnt_i);
    start     = dwa_en_i ? 32'(ptr_q) : 0;
    mask_full = rot_therm(n, start, N_ELEM);
    sel_d     = mask_full[N_ELEM-1:0];
    sum       = start + n;
    if (sum >= N_ELEM) sum = sum - N_ELEM;
    ptr_d     = dwa_en_i ? PTR_W'(sum) : '0;
  end

  // Bits above N_ELEM are always zero; folded here only so they have a reader.
  assign unused_mask_hi = ^mask_full;

  // Mask and pointer update together so the pointer always names the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      ptr_q <= '0;
    end else if (clk_en_i) begin
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end

  assign sel_o = sel_q;
  assign ptr_o = ptr_q;

endmodule

// File: rtl/dwa_sel18.sv
// Two independent DWA banks (A driven by gama, B by beta) plus a registered
// flag marking that either request was clipped to N_ELEM.
module dwa_sel18
  import dwa_sel18_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int PTR_W  = ptr_w(N_ELEM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              dwa_en,
  input  logic [3:0]        gama,
  input  logic [3:0]        beta,
  output logic [N_ELEM-1:0] sel_a,
  output logic [N_ELEM-1:0] sel_b,
  output logic [PTR_W-1:0]  ptr_a,
  output logic [PTR_W-1:0]  ptr_b,
  output logic              sat
);

  logic clip_a, clip_b;
  logic sat_q, sat_d;

  dwa_bank #(.N_ELEM(N_ELEM), .PTR_W(PTR_W)) u_bank_a (
    .clk(clk), .rst(rst), .clk_en_i(clk_en), .dwa_en_i(dwa_en),
    .cnt_i(gama), .sel_o(sel_a), .ptr_o(ptr_a), .clip_o(clip_a)
  );

  dwa_bank #(.N_ELEM(N_ELEM), .PTR_W(PTR_W)) u_bank_b (
    .clk(clk), .rst(rst), .clk_en_i(clk_en), .dwa_en_i(dwa_en),
    .cnt_i(beta), .sel_o(sel_b), .ptr_o(ptr_b), .clip_o(clip_b)
  );

  assign sat_d = clip_a | clip_b;

  // Saturation flag tracks the same sample as the masks it accompanies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sat_q <= 1'b0;
    else if (clk_en) sat_q <= sat_d;
  end

  assign sat = sat_q;

endmodule

// File: tb/tb_dwa_sel18.sv
// Bench for dwa_sel18: directed vector table, then randomized run against a
// reference model with an asynchronous reset pulse mid-run.
module tb_dwa_sel18;

  localparam int N = 9;

  logic       clk = 1'b0;
  logic       rst, clk_en, dwa_en;
  logic [3:0] gama, beta;
  logic [8:0] sel_a, sel_b;
  logic [3:0] ptr_a, ptr_b;
  logic       sat;

  always #5 clk = ~clk;

  dwa_sel18 dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dwa_en(dwa_en),
    .gama(gama), .beta(beta), .sel_a(sel_a), .sel_b(sel_b),
    .ptr_a(ptr_a), .ptr_b(ptr_b), .sat(sat)
  );

  typedef struct {
    logic [8:0] sa;
    logic [3:0] pa;
    logic [8:0] sb;
    logic [3:0] pb;
    logic       st;
  } exp_t;

  typedef struct {
    logic       ce, de;
    logic [3:0] g, b;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  exp_t m;
  vec_t tv[23];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ce, input logic de, input logic [3:0] g,
                              input logic [3:0] b, input logic [8:0] sa, input logic [3:0] pa,
                              input logic [8:0] sb, input logic [3:0] pb, input logic st);
    vec_t v;
    v.ce = ce; v.de = de; v.g = g; v.b = b;
    v.e.sa = sa; v.e.pa = pa; v.e.sb = sb; v.e.pb = pb; v.e.st = st;
    return v;
  endfunction

  function automatic int clipn(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  // Walk the pointer element by element to lay down n ones.
  function automatic logic [8:0] ref_mask(input int n, input int p);
    logic [8:0] r;
    int idx;
    r = '0;
    idx = p;
    for (int k = 0; k < n; k++) begin
      r[idx] = 1'b1;
      idx = (idx == N - 1) ? 0 : idx + 1;
    end
    return r;
  endfunction

  task automatic model_push(input logic ce, input logic de, input logic [3:0] g, input logic [3:0] b);
    int na, nb, pa0, pb0;
    if (ce) begin
      na  = clipn(g);
      nb  = clipn(b);
      pa0 = de ? int'(m.pa) : 0;
      pb0 = de ? int'(m.pb) : 0;
      m.sa = ref_mask(na, pa0);
      m.sb = ref_mask(nb, pb0);
      m.pa = de ? 4'((pa0 + na) % N) : 4'd0;
      m.pb = de ? 4'((pb0 + nb) % N) : 4'd0;
      m.st = (g > 4'd9) || (b > 4'd9);
    end
    sbq.push_back(m);
  endtask

  task automatic model_clear();
    m.sa = '0; m.sb = '0; m.pa = '0; m.pb = '0; m.st = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_sel_a"}, 32'(sel_a), 32'(e.sa));
      chk({tag, "_ptr_a"}, 32'(ptr_a), 32'(e.pa));
      chk({tag, "_sel_b"}, 32'(sel_b), 32'(e.sb));
      chk({tag, "_ptr_b"}, 32'(ptr_b), 32'(e.pb));
      chk({tag, "_sat"},   32'(sat),   32'(e.st));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel_a"}, 32'(sel_a), 32'd0);
    chk({tag, "_ptr_a"}, 32'(ptr_a), 32'd0);
    chk({tag, "_sel_b"}, 32'(sel_b), 32'd0);
    chk({tag, "_ptr_b"}, 32'(ptr_b), 32'd0);
    chk({tag, "_sat"},   32'(sat),   32'd0);
  endtask

  initial begin
    // Hand-derived vectors: rotation, wrap, boundaries, fixed mode, enable hold.
    tv[0]  = mk(1, 1, 3,  0,  9'h007, 3, 9'h000, 0, 0);
    tv[1]  = mk(1, 1, 3,  0,  9'h038, 6, 9'h000, 0, 0);
    tv[2]  = mk(1, 1, 3,  0,  9'h1C0, 0, 9'h000, 0, 0);
    tv[3]  = mk(1, 1, 3,  0,  9'h007, 3, 9'h000, 0, 0);
    tv[4]  = mk(1, 1, 4,  0,  9'h078, 7, 9'h000, 0, 0);
    tv[5]  = mk(1, 1, 4,  0,  9'h183, 2, 9'h000, 0, 0);
    tv[6]  = mk(1, 1, 0,  0,  9'h000, 2, 9'h000, 0, 0);
    tv[7]  = mk(1, 1, 9,  0,  9'h1FF, 2, 9'h000, 0, 0);
    tv[8]  = mk(1, 1, 12, 0,  9'h1FF, 2, 9'h000, 0, 1);
    tv[9]  = mk(1, 0, 1,  5,  9'h001, 0, 9'h01F, 0, 0);
    tv[10] = mk(1, 0, 1,  5,  9'h001, 0, 9'h01F, 0, 0);
    tv[11] = mk(1, 0, 1,  5,  9'h001, 0, 9'h01F, 0, 0);
    tv[12] = mk(1, 1, 1,  5,  9'h001, 1, 9'h01F, 5, 0);
    tv[13] = mk(1, 1, 0,  15, 9'h000, 1, 9'h1FF, 5, 1);
    tv[14] = mk(1, 1, 2,  3,  9'h006, 3, 9'h0E0, 8, 0);
    tv[15] = mk(1, 1, 0,  4,  9'h000, 3, 9'h107, 3, 0);
    tv[16] = mk(1, 0, 0,  0,  9'h000, 0, 9'h000, 0, 0);
    tv[17] = mk(1, 1, 2,  0,  9'h003, 2, 9'h000, 0, 0);
    tv[18] = mk(0, 0, 7,  13, 9'h003, 2, 9'h000, 0, 0);
    tv[19] = mk(0, 1, 2,  0,  9'h003, 2, 9'h000, 0, 0);
    tv[20] = mk(1, 1, 2,  0,  9'h00C, 4, 9'h000, 0, 0);
    tv[21] = mk(1, 1, 10, 0,  9'h1FF, 4, 9'h000, 0, 1);
    tv[22] = mk(0, 1, 0,  0,  9'h1FF, 4, 9'h000, 0, 1);

    // Reset before any clock edge, then across an enabled edge.
    rst = 1'b1; clk_en = 1'b1; dwa_en = 1'b1; gama = 4'd5; beta = 4'd7;
    #3;
    chk_zero("rst_async");
    @(posedge clk); #1;
    chk_zero("rst_prio");
    rst = 1'b0;

    foreach (tv[i]) begin
      clk_en = tv[i].ce; dwa_en = tv[i].de; gama = tv[i].g; beta = tv[i].b;
      sbq.push_back(tv[i].e);
      @(posedge clk); #1;
      pop_check($sformatf("vec%0d", i));
    end

    // Resynchronise the model with a short reset pulse away from the edge.
    rst = 1'b1; #1; rst = 1'b0;
    model_clear();

    for (int i = 0; i < 10000; i++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      dwa_en = ($urandom_range(0, 15) != 0);
      gama   = 4'($urandom_range(0, 15));
      beta   = 4'($urandom_range(0, 15));
      model_push(clk_en, dwa_en, gama, beta);
      @(posedge clk); #1;
      pop_check("rnd");
      if (clk_en)
        chk("rnd_popcount", 32'($countones(sel_a) + $countones(sel_b)),
            32'(clipn(gama) + clipn(beta)));
      if (i == 5000) begin
        #2; rst = 1'b1; #1;
        chk_zero("mid_rst_async");
        @(posedge clk); #1;
        chk_zero("mid_rst_held");
        rst = 1'b0;
        model_clear();
        // First enabled edge after release must start from pointer 0.
        clk_en = 1'b1; dwa_en = 1'b1; gama = 4'd3; beta = 4'd2;
        @(posedge clk); #1;
        chk("restart_sel_a", 32'(sel_a), 32'h007);
        chk("restart_ptr_a", 32'(ptr_a), 32'd3);
        chk("restart_sel_b", 32'(sel_b), 32'h003);
        chk("restart_ptr_b", 32'(ptr_b), 32'd2);
        m.sa = 9'h007; m.pa = 4'd3; m.sb = 9'h003; m.pb = 4'd2; m.st = 1'b0;
      end
    end

    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
